// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the program memory boot loader.
// Holds the loader state encoding, parameter defaults and the hold counter width.
package prog_mem_pkg;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_HOLD,
      ST_RUN,
      ST_ERR
   } state_t;

   localparam int DEPTH_DEF       = 256;
   localparam int ADDR_W_DEF      = 8;
   localparam int HOLD_CYCLES_DEF = 4;
   localparam int HOLD_W          = 4;

endpackage

// File: rtl/prog_mem_ram.sv
// Program byte array: one synchronous write port, one asynchronous read port.
// Write visible on the read port in the cycle after the write edge; no reset on contents.
module prog_mem_ram #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [7:0]        rdata
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/prog_mem_loader.sv
// Boot loader: streams a byte image into program memory and holds the CPU in reset until done.
// Optional PROG_MEM_CHECKSUM_EN: final byte is a checksum; a bad sum or overflow parks in ERR.
module prog_mem_loader
   import prog_mem_pkg::*;
#(
   parameter int DEPTH       = DEPTH_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [7:0]        load_data,
   input  logic              load_last,
   input  logic              reload,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic [7:0]        cpu_data,
   output logic              cpu_rst,
   output logic [ADDR_W:0]   load_count,
   output logic              done,
   output logic              err
);

   state_t              state_q, state_d;
   logic [ADDR_W:0]     load_count_q, load_count_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic                ram_we;
   logic [7:0]          ram_rdata;
   logic                accept;
`ifdef PROG_MEM_CHECKSUM_EN
   logic [7:0]          sum_q, sum_d;
   logic [7:0]          sum_chk;
`endif

   // Reset gates ready combinationally so no byte can be written while rst is low.
   assign load_ready = (state_q == ST_LOAD) && rst;
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d      = state_q;
      load_count_d = load_count_q;
      hold_cnt_d   = hold_cnt_q;
      ram_we       = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
      sum_d        = sum_q;
      sum_chk      = sum_q + load_data;
`endif
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
`ifdef PROG_MEM_CHECKSUM_EN
               if (load_last) begin
                  hold_cnt_d = '0;
                  state_d    = (sum_chk == 8'h00) ? ST_HOLD : ST_ERR;
               end else if (load_count_q == (ADDR_W+1)'(DEPTH)) begin
                  state_d = ST_ERR;
               end else begin
                  ram_we       = 1'b1;
                  load_count_d = load_count_q + 1'b1;
                  sum_d        = sum_chk;
               end
`else
               ram_we       = 1'b1;
               load_count_d = load_count_q + 1'b1;
               if (load_last || (load_count_q == (ADDR_W+1)'(DEPTH-1))) begin
                  hold_cnt_d = '0;
                  state_d    = ST_HOLD;
               end
`endif
            end
         end
         ST_HOLD: begin
            if (hold_cnt_q == HOLD_W'(HOLD_CYCLES-1)) begin
               hold_cnt_d = '0;
               state_d    = ST_RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         ST_RUN, ST_ERR: begin
            if (reload) begin
               state_d      = ST_LOAD;
               load_count_d = '0;
`ifdef PROG_MEM_CHECKSUM_EN
               sum_d        = 8'h00;
`endif
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_LOAD;
         load_count_q <= '0;
         hold_cnt_q   <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
         sum_q        <= 8'h00;
`endif
      end else begin
         state_q      <= state_d;
         load_count_q <= load_count_d;
         hold_cnt_q   <= hold_cnt_d;
`ifdef PROG_MEM_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   prog_mem_ram #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (load_count_q[ADDR_W-1:0]),
      .wdata (load_data),
      .raddr (cpu_addr),
      .rdata (ram_rdata)
   );

   // Bytes beyond the current image (stale or never written) read as zero.
   assign cpu_data   = ({1'b0, cpu_addr} < load_count_q) ? ram_rdata : 8'h00;
   assign load_count = load_count_q;
   assign cpu_rst    = (state_q == ST_RUN);
   assign done       = (state_q == ST_RUN);
`ifdef PROG_MEM_CHECKSUM_EN
   assign err        = (state_q == ST_ERR);
`else
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: inputs driven and outputs sampled on the falling edge.
module tb_prog_mem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_data;
   logic       load_last;
   logic       reload;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_data;
   logic       cpu_rst;
   logic [8:0] load_count;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prog_mem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_last  (load_last),
      .reload     (reload),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_rst    (cpu_rst),
      .load_count (load_count),
      .done       (done),
      .err        (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte for exactly one rising edge; returns on the following falling edge.
   task automatic send(input logic [7:0] d, input logic l);
      load_valid = 1'b1;
      load_data  = d;
      load_last  = l;
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic idle();
      load_valid = 1'b0;
      load_last  = 1'b0;
      load_data  = 8'hEE;
      @(negedge clk);
   endtask

   task automatic read(input logic [7:0] a, input logic [7:0] exp, input string tag);
      cpu_addr = a;
      #1;
      chk(tag, cpu_data, exp);
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   // Checks cpu_rst stays low through the hold window and rises on the 4th edge.
   task automatic check_hold(input string tag);
      chk({tag, "_hold0"}, cpu_rst, 1'b0);
      chk({tag, "_ready_hold"}, load_ready, 1'b0);
      for (int k = 1; k < 4; k++) begin
         idle();
         chk({tag, "_hold"}, cpu_rst, 1'b0);
      end
      idle();
      chk({tag, "_cpu_rst_up"}, cpu_rst, 1'b1);
      chk({tag, "_done_up"}, done, 1'b1);
   endtask

   initial begin
      logic any_nz;
      rst        = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      reload     = 1'b0;
      cpu_addr   = 8'h00;
      @(negedge clk);
      #1;
      chk("ready_in_reset", load_ready, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_count", load_count, 9'd0);
      chk("rst_cpu_rst", cpu_rst, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_ready", load_ready, 1'b1);
      read(8'h00, 8'h00, "rst_masked");

`ifdef PROG_MEM_CHECKSUM_EN
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'hFD, 1'b1);
      check_hold("ck_ok");
      chk("ck_ok_count", load_count, 9'd2);
      read(8'h01, 8'h02, "ck_ok_rd1");
      read(8'h02, 8'h00, "ck_ok_rd2");
      pulse_reload();
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'hFE, 1'b1);
      chk("ck_bad_err", err, 1'b1);
      for (int k = 0; k < 6; k++) idle();
      chk("ck_bad_err_stuck", err, 1'b1);
      chk("ck_bad_cpu_rst", cpu_rst, 1'b0);
      chk("ck_bad_ready", load_ready, 1'b0);
      pulse_reload();
      chk("ck_reload_err", err, 1'b0);
      chk("ck_reload_ready", load_ready, 1'b1);
`else
      // Three-byte image with load_last on the final byte.
      send(8'h11, 1'b0);
      chk("t1_count1", load_count, 9'd1);
      read(8'h00, 8'h11, "t1_write_latency");
      send(8'h22, 1'b0);
      send(8'h33, 1'b1);
      check_hold("t1");
      read(8'h02, 8'h33, "t1_rd2");
      read(8'h03, 8'h00, "t1_rd3");
      read(8'h00, 8'h11, "t1_rd0");
      chk("t1_count", load_count, 9'd3);
      chk("t1_ready_run", load_ready, 1'b0);
      chk("t1_err", err, 1'b0);

      // Reload from RUN, then a one-byte image.
      pulse_reload();
      chk("t4_cpu_rst", cpu_rst, 1'b0);
      chk("t4_done", done, 1'b0);
      chk("t4_ready", load_ready, 1'b1);
      chk("t4_count", load_count, 9'd0);
      send(8'hA5, 1'b1);
      check_hold("t4");
      read(8'h00, 8'hA5, "t4_rd0");
      read(8'h01, 8'h00, "t4_rd1_masked");

      // Full 256-byte image without load_last terminates on index 255.
      pulse_reload();
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 1'b0);
      end
      chk("t2_count", load_count, 9'd256);
      check_hold("t2");
      read(8'hFF, 8'hFF, "t2_rdFF");
      read(8'h80, 8'h80, "t2_rd80");

      // Reset mid-load: earlier bytes are masked by the cleared count.
      pulse_reload();
      for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 1'b0);
      chk("t3_count5", load_count, 9'd5);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t3_count", load_count, 9'd0);
      chk("t3_cpu_rst", cpu_rst, 1'b0);
      any_nz = 1'b0;
      for (int a = 0; a < 256; a++) begin
         cpu_addr = 8'(a);
         #1;
         if (cpu_data !== 8'h00) any_nz = 1'b1;
      end
      chk("t3_all_masked", any_nz, 1'b0);
      @(negedge clk);
      send(8'h5A, 1'b0);
      send(8'h6B, 1'b1);
      check_hold("t3");
      chk("t3_count2", load_count, 9'd2);
      read(8'h00, 8'h5A, "t3_rd0");
      read(8'h01, 8'h6B, "t3_rd1");
      read(8'h02, 8'h00, "t3_rd2_masked");

      // Ten bytes with random stalls on load_valid.
      pulse_reload();
      for (int i = 0; i < 10; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) idle();
         send(8'h70 + 8'(i), i == 9);
         chk("t6_count", load_count, 9'(i + 1));
      end
      check_hold("t6");
      for (int i = 0; i < 10; i++) read(8'(i), 8'h70 + 8'(i), "t6_rd");
      read(8'h0A, 8'h00, "t6_rd10_masked");
      chk("t6_ready_run", load_ready, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Program memory and boot loader sitting directly upstream of `Processor`. It accepts a program as a byte stream over a valid/ready handshake, stores it in a 256x8 array, and serves the processor's instruction fetches combinationally on `cpu_addr`/`cpu_data`. While the load is in progress it holds the processor in reset through `cpu_rst`, then releases it once the image is complete.

## Interface
- `DEPTH`, 256: program memory bytes. Must equal 2**`ADDR_W`.
- `ADDR_W`, 8: address width; matches the `Processor` `Address` bus.
- `HOLD_CYCLES`, 4: cycles `cpu_rst` stays low after the load completes. Range 1..15.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `load_valid` in 1: `load_data` is valid.
- `load_ready` out 1: the loader accepts a byte this cycle.
- `load_data` in 8: program byte.
- `load_last` in 1: qualifies the final byte of the image.
- `reload` in 1: single-cycle request to start a new load; honoured in RUN and ERR only.
- `cpu_addr` in `ADDR_W`: fetch address from `Processor.Address`.
- `cpu_data` out 8: fetch data to `Processor.Data`; combinational.
- `cpu_rst` out 1: active-low reset to `Processor.rst`.
- `load_count` out `ADDR_W`+1: number of bytes written, 0..256.
- `done` out 1: high in RUN.
- `err` out 1: high in ERR.

## Operation
- States: LOAD, HOLD, RUN, ERR.
- LOAD:
  - `load_ready`=1.
  - A byte is accepted on a cycle where `load_valid` and `load_ready` are both 1. It is written to `mem[load_count]`, and `load_count` increments.
  - An accepted byte with `load_last`=1 moves the block to HOLD.
  - Accepting the byte at index 255 also moves the block to HOLD, even without `load_last`.
- HOLD: the hold counter counts `HOLD_CYCLES` cycles, then the block moves to RUN.
- RUN: `cpu_rst`=1 and `done`=1. A `reload` pulse moves the block to LOAD and clears `load_count`. Memory contents are not cleared.
- ERR: `cpu_rst`=0 and `err`=1. Only `reload` or `rst` leaves ERR.
- `cpu_data` = `mem[cpu_addr]` when `cpu_addr` < `load_count`; otherwise 8'h00. This holds in every state.
- `load_ready`=0 in every state other than LOAD, and also whenever `rst`=0.
- `reload` in LOAD or HOLD is ignored.

## Timing
- Reset values (cycle after a rising edge with `rst`=0):
  - state = LOAD, `load_count`=0, hold counter=0.
  - `cpu_rst`=0, `done`=0, `err`=0.
  - Memory is unchanged.
- `rst` low mid-load aborts the load. Bytes already written stay in memory, but are masked because `load_count`=0.
- Write latency: a byte accepted at edge N is readable on `cpu_data` after edge N, i.e. in cycle N+1.
- `cpu_rst` rises exactly `HOLD_CYCLES` cycles after the edge that accepts the final byte. `done` rises in the same cycle as `cpu_rst`.
- A `reload` sampled at edge N drops `cpu_rst`, `done` and `err`, and raises `load_ready`, all in cycle N+1.
- Back-to-back accepts are allowed every cycle; there are no bubbles.

## Configuration
- `PROG_MEM_CHECKSUM_EN` defined:
  - The byte accepted with `load_last` is a checksum. It is not written and does not increment `load_count`.
  - An 8-bit running sum covers all data bytes plus the checksum byte. Sum == 8'h00 moves the block to HOLD; any other sum moves it to ERR.
  - Index 255 does not auto-terminate the load. An attempt to accept a data byte while `load_count`=256 moves the block to ERR instead of writing.
- `PROG_MEM_CHECKSUM_EN` undefined: no checksum; the `load_last` byte is ordinary data. `err` is tied to 0 and ERR is unreachable.

## Structure
- Package `prog_mem_pkg` holds:
  - the state enum (LOAD, HOLD, RUN, ERR);
  - default constants for `DEPTH`, `ADDR_W` and `HOLD_CYCLES`;
  - the hold counter width (4).
- Sub-module `prog_mem_ram`: `DEPTH`x8 array with a single synchronous write port and an asynchronous read port. It has no reset.
- The loader FSM, counters, read mask and checksum stay in `prog_mem_loader`.

## Test plan
- Load 3 bytes 8'h11, 8'h22, 8'h33 with `load_last` on the third (no checksum):
  - `cpu_rst` rises 4 cycles after the last accept;
  - `cpu_addr`=2 gives 8'h33; `cpu_addr`=3 gives 8'h00; `load_count`=3.
- Hold `load_valid` high continuously for 256 bytes, value = index, with no `load_last`:
  - HOLD is entered after byte 255;
  - `load_count`=256; `cpu_addr`=8'hFF gives 8'hFF.
- Pulse `rst` low mid-load after 5 bytes:
  - `load_count`=0, `cpu_rst`=0, and `cpu_data`=8'h00 at every address;
  - a new load of 2 bytes completes normally.
- In RUN, pulse `reload`, then load 1 byte 8'hA5 with `load_last`:
  - `cpu_rst` goes low for the whole reload and hold period, then high;
  - `cpu_addr`=0 gives 8'hA5; `cpu_addr`=1 gives 8'h00.
- With `PROG_MEM_CHECKSUM_EN`, load data 8'h01, 8'h02 and checksum 8'hFD:
  - RUN is reached with `load_count`=2.
  - Repeating with checksum 8'hFE gives `err`=1 and `cpu_rst` stuck at 0 until `reload`.
- Drive `load_valid` with a random stall pattern on `load_valid` during a 10-byte load:
  - every byte is written exactly once, in order;
  - `load_ready` is 0 in HOLD, RUN and ERR.
